// File: rtl/cpu_debug_pkg.sv
// Shared definitions for the JTAG debug command bridge: default register
// widths, the command record layout and a constant-foldable clog2.
package cpu_debug_pkg;

    localparam int DEF_IR_W = 2;
    localparam int DEF_DR_W = 38;

    // One queued debug command: the instruction latched at update-IR and
    // the data register captured at update-DR.
    typedef struct packed {
        logic [DEF_IR_W-1:0] ir;
        logic [DEF_DR_W-1:0] data;
    } cmd_rec_t;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cpu_jtag_debug_cmd_bridge_if.sv
// Command-queue head handshake between the bridge (master) and the
// debug consumer (slave).
interface cpu_jtag_debug_cmd_bridge_if
    import cpu_debug_pkg::*;
#(
    parameter int IR_W = DEF_IR_W,
    parameter int DR_W = DEF_DR_W
);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_data;
    logic            cmd_action;

    modport master (
        output cmd_valid,
        output cmd_ir,
        output cmd_data,
        output cmd_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ir,
        input  cmd_data,
        input  cmd_action,
        output cmd_ready
    );

endinterface

// File: rtl/cpu_debug_cmd_fifo.sv
// First-word-fall-through FIFO with an exact occupancy count. The head is
// kept in a register so it holds its last value once the FIFO drains.
module cpu_debug_cmd_fifo
    import cpu_debug_pkg::*;
#(
    parameter int WIDTH = DEF_IR_W + DEF_DR_W,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_din,
    output logic                    o_drop,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [WIDTH-1:0]        o_dout,
    output logic [clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int LVL_W = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_head;

    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;
    logic [PTR_W-1:0] w_rd_next;
    logic [WIDTH-1:0] w_head_next;

    assign w_valid   = (r_level != '0);
    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_pop     = w_valid & i_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push & (~w_full | w_pop);
    assign w_rd_next = r_rd_ptr + PTR_W'(1);

    assign o_drop  = i_push & w_full & ~w_pop;
    assign o_valid = w_valid;
    assign o_dout  = r_head;
    assign o_level = r_level;

    // Storage write; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Select the next head: the entry behind the popped one, or the incoming
    // word when it lands in an otherwise empty FIFO; otherwise hold.
    always_comb begin
        w_head_next = r_head;
        if (w_pop) begin
            if (r_level > LVL_W'(1)) begin
                w_head_next = r_mem[w_rd_next];
            end else if (w_push_ok) begin
                w_head_next = i_din;
            end
        end else if (w_push_ok && !w_valid) begin
            w_head_next = i_din;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            r_head <= w_head_next;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/cpu_jtag_debug_cmd_bridge.sv
// Bridges virtual-JTAG update-IR/update-DR events into a command queue in
// the clk domain. Each update-DR pushes {current IR, shift register}.
module cpu_jtag_debug_cmd_bridge
    import cpu_debug_pkg::*;
#(
    parameter int IR_W        = DEF_IR_W,
    parameter int DR_W        = DEF_DR_W,
    parameter int SYNC_STAGES = 2,
    parameter int CMD_DEPTH   = 4,
    parameter int ACT_BIT     = DR_W - 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        vs_uir,
    input  logic                        vs_udr,
    input  logic [IR_W-1:0]             ir_in,
    input  logic [DR_W-1:0]             sr,
    cpu_jtag_debug_cmd_bridge_if.master cmd_if,
    output logic [clog2(CMD_DEPTH):0]   level,
    output logic                        overflow,
    input  logic                        clear_overflow
);

    localparam int CMD_W = IR_W + DR_W;

    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic                   r_uir_prev;
    logic                   r_udr_prev;
    // Fills with ones after reset; edges are only trusted once both the
    // last sync stage and its delayed copy hold real samples, so a level
    // held high across reset never looks like a rising edge.
    logic [SYNC_STAGES:0]   r_arm;
    logic [IR_W-1:0]        r_cur_ir;
    logic                   r_overflow;

    logic                   w_uir_p;
    logic                   w_udr_p;
    logic                   w_drop;
    logic                   w_valid;
    logic [CMD_W-1:0]       w_head;

    // Synchronizer chains, delayed last stage and post-reset arming.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_uir_sync <= '0;
            r_udr_sync <= '0;
            r_uir_prev <= 1'b0;
            r_udr_prev <= 1'b0;
            r_arm      <= '0;
        end else begin
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_prev <= r_uir_sync[SYNC_STAGES-1];
            r_udr_prev <= r_udr_sync[SYNC_STAGES-1];
            r_arm      <= {r_arm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_uir_p = r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev & r_arm[SYNC_STAGES];
    assign w_udr_p = r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev & r_arm[SYNC_STAGES];

    // Current instruction; a coincident push has already sampled the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_ir <= '0;
        end else if (w_uir_p) begin
            r_cur_ir <= ir_in;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    cpu_debug_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_udr_p),
        .i_din   ({r_cur_ir, sr}),
        .o_drop  (w_drop),
        .o_valid (w_valid),
        .i_ready (cmd_if.cmd_ready),
        .o_dout  (w_head),
        .o_level (level)
    );

    assign cmd_if.cmd_valid  = w_valid;
    assign cmd_if.cmd_ir     = w_head[CMD_W-1:DR_W];
    assign cmd_if.cmd_data   = w_head[DR_W-1:0];
    assign cmd_if.cmd_action = w_head[ACT_BIT];
    assign overflow          = r_overflow;

endmodule

// File: tb/tb_cpu_jtag_debug_cmd_bridge.sv
// Self-checking bench: directed scenarios plus random JTAG traffic, checked
// against a queue-based model of the command bridge.
module tb_cpu_jtag_debug_cmd_bridge;
    import cpu_debug_pkg::*;

    localparam int IR_W  = 2;
    localparam int DR_W  = 38;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            vs_uir = 1'b0;
    logic            vs_udr = 1'b0;
    logic [IR_W-1:0] ir_in = '0;
    logic [DR_W-1:0] sr = '0;
    logic [2:0]      level;
    logic            overflow;
    logic            clear_overflow = 1'b0;

    cpu_jtag_debug_cmd_bridge_if #(.IR_W(IR_W), .DR_W(DR_W)) cmd_if ();

    cpu_jtag_debug_cmd_bridge #(
        .IR_W        (IR_W),
        .DR_W        (DR_W),
        .SYNC_STAGES (2),
        .CMD_DEPTH   (DEPTH),
        .ACT_BIT     (DR_W - 1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_if         (cmd_if),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queued commands, current IR, sticky flag, last head shown.
    cmd_rec_t        mq[$];
    cmd_rec_t        m_last;
    logic [IR_W-1:0] m_cur_ir;
    logic            m_ov;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".valid"},  64'(cmd_if.cmd_valid),  64'(mq.size() != 0));
        chk({tag, ".level"},  64'(level),             64'(mq.size()));
        chk({tag, ".ovf"},    64'(overflow),          64'(m_ov));
        chk({tag, ".ir"},     64'(cmd_if.cmd_ir),     64'(m_last.ir));
        chk({tag, ".data"},   64'(cmd_if.cmd_data),   64'(m_last.data));
        chk({tag, ".action"}, 64'(cmd_if.cmd_action), 64'(m_last.data[DR_W-1]));
    endtask

    // Effect of one clk edge carrying optional uir/udr pulses, pop request and clear.
    task automatic model_apply(input bit do_uir, input logic [IR_W-1:0] irv,
                               input bit do_udr, input logic [DR_W-1:0] srv,
                               input bit rdy, input bit clr);
        bit       drop;
        cmd_rec_t rec;
        drop = 1'b0;
        if (rdy && mq.size() > 0) begin
            void'(mq.pop_front());
        end
        if (do_udr) begin
            if (mq.size() < DEPTH) begin
                rec.ir   = m_cur_ir;
                rec.data = srv;
                mq.push_back(rec);
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
        if (do_uir) m_cur_ir = irv;
        if (mq.size() > 0) m_last = mq[0];
    endtask

    task automatic model_reset();
        mq.delete();
        m_last   = '0;
        m_cur_ir = '0;
        m_ov     = 1'b0;
    endtask

    // Raise the requested JTAG strobes; they reach the queue three edges later,
    // and cmd_ready/clear_overflow are driven for exactly that edge.
    task automatic jtag_event(input bit do_uir, input logic [IR_W-1:0] irv,
                              input bit do_udr, input logic [DR_W-1:0] srv,
                              input bit rdy, input bit clr);
        @(negedge clk);
        if (do_uir) begin ir_in = irv; vs_uir = 1'b1; end
        if (do_udr) begin sr = srv; vs_udr = 1'b1; end
        @(negedge clk);
        @(negedge clk);
        cmd_if.cmd_ready = rdy;
        clear_overflow   = clr;
        @(negedge clk);
        cmd_if.cmd_ready = 1'b0;
        clear_overflow   = 1'b0;
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        model_apply(do_uir, irv, do_udr, srv, rdy, clr);
        $display("event uir=%0d ir=%0h udr=%0d sr=%0h rdy=%0d clr=%0d -> level=%0d", do_uir, irv, do_udr, srv, rdy, clr, mq.size());
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        cmd_if.cmd_ready = 1'b1;
        @(negedge clk);
        cmd_if.cmd_ready = 1'b0;
        model_apply(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        $display("pop -> level=%0d", mq.size());
    endtask

    function automatic logic [DR_W-1:0] rand_sr();
        return {6'($urandom), $urandom};
    endfunction

    initial begin
        model_reset();
        cmd_if.cmd_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_state("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single command with action bit set
        jtag_event(1'b1, 2'b01, 1'b0, '0, 1'b0, 1'b0);
        jtag_event(1'b0, '0, 1'b1, 38'h20_0000_1234, 1'b0, 1'b0);
        check_state("single");
        chk("single.ir_const",   64'(cmd_if.cmd_ir),     64'h1);
        chk("single.data_const", 64'(cmd_if.cmd_data),   64'h20_0000_1234);
        chk("single.act_const",  64'(cmd_if.cmd_action), 64'h1);
        chk("single.lvl_const",  64'(level),             64'h1);
        pop_one();
        check_state("single_pop");

        // Overflow: five pushes into depth four
        for (int i = 0; i < 5; i++) begin
            jtag_event(1'b0, '0, 1'b1, 38'(64'h100 + 64'(i)), 1'b0, 1'b0);
        end
        check_state("full");
        chk("full.lvl_const", 64'(level),    64'h4);
        chk("full.ovf_const", 64'(overflow), 64'h1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d.order", i), 64'(cmd_if.cmd_data), 64'h100 + 64'(i));
            pop_one();
            check_state($sformatf("drain%0d", i));
        end

        // Clear alone
        jtag_event(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        check_state("clear_alone");

        // Push into a full queue while popping
        for (int i = 0; i < 4; i++) jtag_event(1'b0, '0, 1'b1, rand_sr(), 1'b0, 1'b0);
        jtag_event(1'b0, '0, 1'b1, 38'h3A_5A5A_5A5A, 1'b1, 1'b0);
        check_state("full_pushpop");
        chk("full_pushpop.ovf_const", 64'(overflow), 64'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("full_pushpop.last", 64'(cmd_if.cmd_data), 64'h3A_5A5A_5A5A);
            pop_one();
            check_state($sformatf("fpp_drain%0d", i));
        end

        // Aligned uir/udr: push takes the old instruction
        jtag_event(1'b1, 2'b01, 1'b0, '0, 1'b0, 1'b0);
        jtag_event(1'b1, 2'b10, 1'b1, rand_sr(), 1'b0, 1'b0);
        check_state("aligned");
        chk("aligned.ir_const", 64'(cmd_if.cmd_ir), 64'h1);
        jtag_event(1'b0, '0, 1'b1, rand_sr(), 1'b0, 1'b0);
        pop_one();
        check_state("aligned_next");
        chk("aligned_next.ir_const", 64'(cmd_if.cmd_ir), 64'h2);
        pop_one();

        // Clear coinciding with a drop
        for (int i = 0; i < 5; i++) jtag_event(1'b0, '0, 1'b1, rand_sr(), 1'b0, 1'b0);
        check_state("drop_set");
        jtag_event(1'b0, '0, 1'b1, rand_sr(), 1'b0, 1'b1);
        check_state("drop_vs_clear");
        chk("drop_vs_clear.ovf_const", 64'(overflow), 64'h1);
        jtag_event(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        chk("clear_after.ovf_const", 64'(overflow), 64'h0);
        for (int i = 0; i < 4; i++) begin
            pop_one();
            check_state($sformatf("dvc_drain%0d", i));
        end
        pop_one();
        check_state("pop_empty");

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pop_one();
            end else begin
                jtag_event(1'($urandom_range(0, 1)), 2'($urandom), ($urandom_range(0, 3) != 0),
                           rand_sr(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            end
            check_state($sformatf("rand%0d", i));
        end

        // Reset mid-stream with vs_udr held high
        while (mq.size() > 0) pop_one();
        for (int i = 0; i < 3; i++) jtag_event(1'b0, '0, 1'b1, rand_sr(), 1'b0, 1'b0);
        check_state("pre_reset");
        @(negedge clk);
        sr     = rand_sr();
        vs_udr = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_state("in_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        $display("reset released with vs_udr high");
        repeat (10) @(negedge clk);
        check_state("post_reset_held");
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
        check_state("post_reset_low");
        jtag_event(1'b0, '0, 1'b1, 38'h15_0000_00FF, 1'b0, 1'b0);
        check_state("post_reset_push");
        chk("post_reset_push.ir_const", 64'(cmd_if.cmd_ir), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
